// File: rtl/div_ctrl.sv
// div_ctrl: multicycle restoring divider sequencer for div/divu.
// Accepts one request in IDLE, converts signed operands to magnitudes,
// produces one quotient bit per clock, then sign-fixes and writes HI/LO.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, is_signed      request pulse and signed/unsigned select (IDLE only)
//   dividend, divisor     operands, captured with start
//   busy                  high whenever not IDLE
//   done                  one-cycle pulse, hi/lo valid in the same cycle
//   div_zero              one-cycle pulse, divisor was zero, nothing written
//   hi, lo                remainder and quotient
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state_q, state_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_d, done_d, div_zero_d;
  logic [WIDTH-1:0] hi_d, lo_d;

  // Partial remainder shifted by one with the next dividend bit appended
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;

  assign rem_sh  = {rem_q[WIDTH-1:0], a_q[cnt_q]};
  assign rem_sub = rem_sh - {1'b0, b_q};

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sgn_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state_q   <= state_d;
      sgn_q     <= sgn_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      div_zero  <= div_zero_d;
      hi        <= hi_d;
      lo        <= lo_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    sgn_d      = sgn_q;
    a_d        = a_q;
    b_d        = b_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi;
    lo_d       = lo;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            div_zero_d = 1'b1;
          end else begin
            a_d     = dividend;
            b_d     = divisor;
            sgn_d   = is_signed;
            state_d = PREP;
          end
        end
      end
      PREP: begin
        if (sgn_q) begin
          a_d       = a_q[WIDTH-1] ? (~a_q + WIDTH'(1)) : a_q;
          b_d       = b_q[WIDTH-1] ? (~b_q + WIDTH'(1)) : b_q;
          neg_quo_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
          neg_rem_d = a_q[WIDTH-1];
        end else begin
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
        end
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = CW'(WIDTH - 1);
        state_d = ITER;
      end
      ITER: begin
        if (rem_sh >= {1'b0, b_q}) begin
          rem_d = rem_sub;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        lo_d    = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
        hi_d    = neg_rem_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule
